alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one instance of the team's combinational `alu` among NREQ requesters, such as the core's execute stage, an address-generation unit and a debug port.
- Each requester uses a valid/ready request channel. A round-robin grant picks one request per cycle.
- The chosen request's operands go through the shared ALU. The result is registered into a single output slot, tagged with the requester index.
- Downstream drains the slot with a valid/ready response channel. Latency is 1 cycle at full throughput.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response tag width; must equal $clog2(NREQ), minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  operand A, packed; requester i occupies [32*i+31:32*i].
- req_b  in  NREQ*32  operand B, packed the same way.
- req_op  in  NREQ*3  ALU opcode, packed; requester i occupies [3*i+2:3*i].
- rsp_valid  out  1  output slot holds a result.
- rsp_ready  in  1  downstream accepts the result.
- rsp_y  out  32  registered ALU result.
- rsp_id  out  IDW  index of the requester that produced rsp_y.
- busy_cnt  out  8  saturating count of cycles with valid requests but no accept (stall monitor).

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_y=0, rsp_id=0, busy_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - A reset asserted mid-transfer discards the held result; no response is produced for it.
- Opcodes are the ALU encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT, signed; result is 1 or 0.
  - 110/111 give result 0. They are still accepted and answered, not errors.
  - Arithmetic wraps mod 2^32.
- slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Scan requesters starting at rr_ptr, rr_ptr+1, ... mod NREQ.
  - The first one with req_valid=1 is granted.
  - req_ready[g] = slot_free and that requester is granted; all other req_ready bits are 0.
  - With no valid requests, or slot_free=0, req_ready=0.
- Accept is a cycle where req_valid[g] && req_ready[g]. On an accept, at the next edge:
  - rsp_y <= alu(a_g, b_g, op_g).
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- Drain without a new accept (rsp_valid && rsp_ready): rsp_valid <= 0.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1. This gives back-to-back throughput of one op per cycle.
- Backpressure (rsp_valid && !rsp_ready):
  - rsp_y and rsp_id hold stable.
  - All req_ready=0.
  - rr_ptr holds.
- Requester rules:
  - Once req_valid is asserted, it stays high with stable a/b/op until accepted.
  - req_valid must not depend combinationally on req_ready.
  - The arbiter's req_ready may depend on req_valid.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0. Any requester waits at most NREQ-1 accepts.
- busy_cnt increments by 1 each cycle where |req_valid && no accept. It saturates at 255 and never wraps.
- rr_ptr changes only on an accept. It is never left pointing outside 0..NREQ-1, including for non-power-of-2 NREQ.

Decomposition:
- Shared package holds:
  - ALU opcode constants: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_SLT=3'b101.
  - XLEN=32.
- Instantiates the existing `alu` unchanged; no ALU logic is duplicated.
- One natural sub-module: rr_arbiter. Inputs are NREQ request bits and the pointer; outputs are a one-hot grant plus a binary index. It is reusable for other shared resources.

Test Plan:
1. Reset, then only requester 2 valid with a=7, b=5, op=001 and rsp_ready=1 → req_ready=0100 in that cycle. Next cycle rsp_valid=1, rsp_y=2, rsp_id=2.
2. All 4 requesters valid continuously, requester i with a=i, b=10, op=000, rsp_ready=1 → one accept per cycle. rsp_id sequence is 0,1,2,3,0 and rsp_y is 10,11,12,13,10.
3. Requester 0 SLT with a=32'hFFFF_FFFF, b=1 → rsp_y=1. Then SLT with a=1, b=32'hFFFF_FFFF → rsp_y=0. Then op=111 → rsp_y=0 with rsp_valid=1.
4. Result held (rsp_valid=1) with rsp_ready=0 for 5 cycles while requesters 1 and 3 are valid → req_ready=0 for all 5 cycles and rsp_y/rsp_id stable. busy_cnt rises by 5. Raising rsp_ready drains the slot and accepts requester 1 in the same cycle.
5. ADD with a=32'hFFFF_FFFF, b=1 → rsp_y=0. SUB with a=0, b=1 → rsp_y=32'hFFFF_FFFF.
6. Assert rst_n=0 asynchronously mid-cycle while rsp_valid=1 → rsp_valid, rsp_y and busy_cnt go to 0 immediately. After release the first grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: datapath width and opcode encoding.
package alu_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by several units. Unused opcodes produce zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Outer loop walks priority order; inner loop maps the offset to a fixed position
  // so every bit select uses a plain loop index.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int p = 0; p < NREQ; p++) begin
        if (!any && req[p] && (p == (int'(ptr) + k) % NREQ)) begin
          any      = 1'b1;
          grant[p] = 1'b1;
          idx      = IDW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ valid/ready requesters; the result lands in a single
// registered slot tagged with the requester index.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_y,
  output logic [IDW-1:0]     rsp_id,
  output logic [7:0]         busy_cnt
);

  logic [XLEN-1:0] a_arr [NREQ];
  logic [XLEN-1:0] b_arr [NREQ];
  logic [2:0]      op_arr[NREQ];

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            any_req;
  logic            slot_free;
  logic            accept;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_next;
  logic [XLEN-1:0] alu_y;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[32*gi +: 32];
    assign b_arr[gi]  = req_b[32*gi +: 32];
    assign op_arr[gi] = req_op[3*gi +: 3];
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  alu u_alu (
    .a  (a_arr[gidx]),
    .b  (b_arr[gidx]),
    .op (op_arr[gidx]),
    .y  (alu_y)
  );

  assign slot_free   = !rsp_valid || rsp_ready;
  assign req_ready   = slot_free ? grant : '0;
  assign accept      = slot_free && any_req;
  // Explicit wrap keeps the pointer in range when NREQ is not a power of two.
  assign rr_ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      busy_cnt  <= '0;
    end else begin
      if (accept) begin
        rsp_y     <= alu_y;
        rsp_id    <= gidx;
        rsp_valid <= 1'b1;
        rr_ptr    <= rr_ptr_next;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (|req_valid && !accept && busy_cnt != 8'hFF) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: cycle model of the arbitration rules plus directed literal checks.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ*3-1:0]  req_op = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [31:0]        rsp_y;
  logic [IDW-1:0]     rsp_id;
  logic [7:0]         busy_cnt;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Model state represents what the DUT must hold after the upcoming rising edge.
  logic        m_valid = 1'b0;
  logic [31:0] m_y = '0;
  int          m_id = 0;
  int          m_ptr = 0;
  int          m_busy = 0;

  always @(negedge clk) begin
    int g;
    int j;
    bit sf;
    logic [NREQ-1:0] exp_ready;
    if (!rst_n) begin
      m_valid = 1'b0; m_y = '0; m_id = 0; m_ptr = 0; m_busy = 0;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_y", rsp_y, 32'd0);
      check("rst_busy", 32'(busy_cnt), 32'd0);
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_y", rsp_y, m_y);
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
      if (rsp_valid && rsp_ready)
        $display("rsp id=%0d y=%h busy=%0d t=%0t", rsp_id, rsp_y, busy_cnt, $time);
      sf = !m_valid || rsp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
      exp_ready = (sf && g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (sf && g >= 0) begin
        m_y = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], req_op[3*g +: 3]);
        m_id = g;
        m_valid = 1'b1;
        m_ptr = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      if (req_valid != 0 && !(sf && g >= 0) && m_busy < 255) m_busy++;
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] acc;

    // 1: single requester, SUB
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 32'd7, 32'd5, 3'b001);
    req_valid = 4'b0100;
    #1 check("t1_ready", 32'(req_ready), 32'b0100);
    step();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_y", rsp_y, 32'd2);
    check("t1_id", 32'(rsp_id), 32'd2);
    req_valid = '0;

    // 2: fair rotation at full throughput
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd10, 3'b000);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_id", 32'(rsp_id), 32'(k % 4));
      check("t2_y", rsp_y, 32'(10 + k % 4));
    end
    req_valid = '0;

    // 3: SLT signed and an unused opcode
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b101);
    req_valid = 4'b0001;
    step();
    check("t3_slt_neg", rsp_y, 32'd1);
    set_req(0, 32'd1, 32'hFFFF_FFFF, 3'b101);
    step();
    check("t3_slt_pos", rsp_y, 32'd0);
    set_req(0, 32'd5, 32'd5, 3'b111);
    step();
    check("t3_op7_y", rsp_y, 32'd0);
    check("t3_op7_valid", 32'(rsp_valid), 32'd1);
    req_valid = '0;

    // 4: backpressure holds the slot, then drain+accept in one cycle
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 32'd3, 32'd4, 3'b000);
    req_valid = 4'b0001;
    step();
    check("t4_first_y", rsp_y, 32'd7);
    set_req(1, 32'd20, 32'd22, 3'b000);
    set_req(3, 32'd1, 32'd1, 3'b000);
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_stall_ready", 32'(req_ready), 32'd0);
      check("t4_stall_y", rsp_y, 32'd7);
      check("t4_stall_id", 32'(rsp_id), 32'd0);
      step();
    end
    check("t4_busy", 32'(busy_cnt), 32'd5);
    rsp_ready = 1'b1;
    #1 check("t4_drain_ready", 32'(req_ready), 32'b0010);
    step();
    check("t4_acc_y", rsp_y, 32'd42);
    check("t4_acc_id", 32'(rsp_id), 32'd1);
    req_valid = 4'b1000;
    step();
    check("t4_next_id", 32'(rsp_id), 32'd3);
    req_valid = '0;

    // 5: wrap-around arithmetic
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b000);
    req_valid = 4'b0001;
    step();
    check("t5_add_wrap", rsp_y, 32'd0);
    check("t5_add_valid", 32'(rsp_valid), 32'd1);
    set_req(0, 32'd0, 32'd1, 3'b001);
    step();
    check("t5_sub_wrap", rsp_y, 32'hFFFF_FFFF);
    req_valid = '0;

    // 6: asynchronous reset while a result is held
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 32'd9, 32'd1, 3'b000);
    req_valid = 4'b0001;
    step();
    check("t6_y", rsp_y, 32'd10);
    set_req(1, 32'd5, 32'd6, 3'b000);
    set_req(3, 32'd2, 32'd2, 3'b000);
    req_valid = 4'b1010;
    repeat (3) step();
    check("t6_busy", 32'(busy_cnt), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(rsp_valid), 32'd0);
    check("t6_async_y", rsp_y, 32'd0);
    check("t6_async_busy", 32'(busy_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("t6_post_ready", 32'(req_ready), 32'b0010);
    step();
    check("t6_post_id", 32'(rsp_id), 32'd1);
    check("t6_post_y", rsp_y, 32'd11);
    req_valid = '0;

    // busy_cnt saturation under long backpressure
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd1, 3'b010);
    req_valid = 4'hF;
    repeat (300) step();
    check("sat_busy", 32'(busy_cnt), 32'd255);
    req_valid = '0;

    // randomized traffic obeying the requester hold rules
    do_reset();
    acc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rsp_ready = ((cyc % 200) < 20) ? 1'b0 : ($urandom_range(3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          set_req(i, rnd_operand(), rnd_operand(), 3'($urandom_range(7)));
          req_valid[i] = 1'b1;
        end
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
